// File: rtl/addsub_result_accum.sv
`default_nettype none
// ============================================================================
// Module   : addsub_result_accum
// Purpose  : Buffers signed 4-bit add/sub results in a small FIFO, drains them
//            into a saturating signed accumulator and presents one windowed
//            sum (plus a sticky saturation flag) every WINDOW samples.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready/in_data  - 4-bit sample input handshake
//            clear                      - synchronous flush of FIFO and window
//            out_valid/out_ready        - windowed sum output handshake
//            out_sum, out_sat           - registered sum and saturation flag
//            fifo_count                 - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module addsub_result_accum #(
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 8,
  parameter int WINDOW = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_data,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic                         out_sat,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(WINDOW + 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [3:0]        mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              mem_we;
  logic [3:0]        entry;
  logic [ACC_W:0]    sum_wide;

  // Full-ness comes from the registered count only: a pop in the same cycle
  // never frees space for a push into a full FIFO.
  assign in_ready   = (count_q != CW'(DEPTH));
  assign out_valid  = (state_q == ST_HOLD);
  assign out_sum    = acc_q;
  assign out_sat    = sat_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    scnt_d   = scnt_q;
    mem_we   = 1'b0;

    push     = in_valid && in_ready;
    pop      = (state_q == ST_ACCUM) && (count_q != '0);
    entry    = mem_q[rd_ptr_q];
    // One guard bit: overflow shows up as the top two bits disagreeing.
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-3){entry[3]}}, entry};

    if (clear) begin
      state_d  = ST_ACCUM;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      acc_d    = '0;
      sat_d    = 1'b0;
      scnt_d   = '0;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
          acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_wide[ACC_W-1:0];
        end
        scnt_d = scnt_q + SW'(1);
        if (scnt_q == SW'(WINDOW - 1)) begin
          state_d = ST_HOLD;
        end
      end

      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end

      if ((state_q == ST_HOLD) && out_ready) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        sat_d   = 1'b0;
        scnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      scnt_q   <= scnt_d;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_result_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_result_accum
// Purpose  : Directed self-checking bench for addsub_result_accum. Two
//            instances (ACC_W=8 and ACC_W=6) share all inputs; FIFO and
//            window flow do not depend on ACC_W, so both stay in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_result_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clear;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_sat8;
  logic [7:0] out_sum8;
  logic [2:0] fifo_count8;
  logic       in_ready6, out_valid6, out_sat6;
  logic [5:0] out_sum6;
  logic [2:0] fifo_count6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addsub_result_accum #(.DEPTH(4), .ACC_W(8), .WINDOW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .clear(clear), .out_valid(out_valid8),
    .out_ready(out_ready), .out_sum(out_sum8), .out_sat(out_sat8),
    .fifo_count(fifo_count8)
  );

  addsub_result_accum #(.DEPTH(4), .ACC_W(6), .WINDOW(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .in_data(in_data), .clear(clear), .out_valid(out_valid6),
    .out_ready(out_ready), .out_sum(out_sum6), .out_sat(out_sat6),
    .fifo_count(fifo_count6)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic push(input int v);
    bit accepted = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'(v);
    for (int t = 0; t < 20; t++) begin
      if (in_ready8) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) chk("push_timeout", 0, 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  // Push eight samples back-to-back with out_ready high; check the pulse.
  task automatic run_window(input string tag, input int v[8],
                            input int e8, input int s8,
                            input int e6, input int s6);
    for (int i = 0; i < 8; i++) push(v[i]);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early_valid"}, int'(out_valid8), 0);
    @(negedge clk);
    chk({tag, "_valid8"}, int'(out_valid8), 1);
    chk({tag, "_valid6"}, int'(out_valid6), 1);
    chk({tag, "_sum8"}, int'($signed(out_sum8)), e8);
    chk({tag, "_sat8"}, int'(out_sat8), s8);
    chk({tag, "_sum6"}, int'($signed(out_sum6)), e6);
    chk({tag, "_sat6"}, int'(out_sat6), s6);
    @(negedge clk);
    chk({tag, "_pulse_end"}, int'(out_valid8), 0);
    chk({tag, "_restart_sum"}, int'($signed(out_sum8)), 0);
  endtask

  initial begin
    int v[8];
    bit ok;

    // 1. Reset with a sample presented
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'd5; clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_valid", int'(out_valid8), 0);
    chk("rst_sum", int'(out_sum8), 0);
    chk("rst_sat", int'(out_sat8), 0);
    chk("rst_count", int'(fifo_count8), 0);
    chk("rst_ready", int'(in_ready8), 1);
    @(negedge clk);
    chk("rst_nostore", int'(fifo_count8), 0);

    // 2. Basic window: 3-2+1+0-8+7+5-1 = 5
    v = '{3, -2, 1, 0, -8, 7, 5, -1};
    run_window("basic", v, 5, 0, 5, 0);

    // 3. Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(1);
    for (int i = 0; i < 4; i++) push(2);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd2;
    chk("bp_count_full", int'(fifo_count8), 4);
    chk("bp_ready_low", int'(in_ready8), 0);
    chk("bp_valid", int'(out_valid8), 1);
    chk("bp_sum", int'($signed(out_sum8)), 8);
    repeat (2) @(negedge clk);
    chk("bp_sum_stable", int'($signed(out_sum8)), 8);
    chk("bp_count_stable", int'(fifo_count8), 4);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_ready_return", int'(ok), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (fifo_count8 == 3'd0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_drained", int'(ok), 1);
    chk("bp_ready_after", int'(in_ready8), 1);
    chk("bp_partial_sum", int'($signed(out_sum8)), 10);
    chk("bp_partial_valid", int'(out_valid8), 0);
    pulse_clear();

    // 4. Saturation (ACC_W=6 instance; ACC_W=8 instance stays in range)
    v = '{7, 7, 7, 7, 7, 7, 7, 7};
    run_window("sat_pos", v, 56, 0, 31, 1);
    v = '{-8, -8, -8, -8, -8, -8, -8, -8};
    run_window("sat_neg", v, -64, 0, -32, 1);
    v = '{7, 7, 7, 7, 7, 7, 7, -8};
    run_window("sat_sticky", v, 41, 0, 23, 1);

    // 5. Clear mid-window, dropping the push in the clear cycle
    for (int i = 0; i < 3; i++) push(4);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd6;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_count", int'(fifo_count8), 0);
    chk("clr_sum", int'($signed(out_sum8)), 0);
    chk("clr_valid", int'(out_valid8), 0);
    v = '{2, 2, 2, 2, 2, 2, 2, 2};
    run_window("clr_after", v, 16, 0, 16, 0);

    // 6. Reset during HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rh_valid_before", int'(out_valid8), 1);
    chk("rh_sum_before", int'($signed(out_sum8)), 8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rh_valid", int'(out_valid8), 0);
    chk("rh_sum", int'($signed(out_sum8)), 0);
    chk("rh_count", int'(fifo_count8), 0);
    out_ready = 1'b1;
    v = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_window("rh_after", v, 8, 0, 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
